// File: rtl/flt_stream_source.sv
`default_nettype none
// ============================================================================
// Module      : flt_stream_source
// Description : AXI4-Stream source stage for the FP reciprocal test. Aligns the
//               counter with the synchronous ROM, frames beats (tlast/tuser),
//               buffers them in a small FIFO and counts dropped beats.
// Revision    : 1.0 - initial release
// ============================================================================
module flt_stream_source #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int ROM_LATENCY = 1,
  parameter int FIRST_ADDR  = 1,
  parameter int LAST_ADDR   = 10,
  parameter int DEPTH       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic [ADDR_W:0]   m_tuser,
  output logic              overflow,
  output logic [7:0]        drop_cnt,
  output logic [15:0]       pkt_cnt
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_ENT_W = DATA_W + 1 + ADDR_W + 1;
  localparam logic [c_PTR_W:0] c_DEPTH = (c_PTR_W + 1)'(DEPTH);

  logic [ROM_LATENCY-1:0]             r_pipe_v;
  logic [ROM_LATENCY-1:0][ADDR_W-1:0] r_pipe_a;
  logic [c_ENT_W-1:0]                 r_mem [DEPTH];
  logic [c_PTR_W-1:0]                 r_wr;
  logic [c_PTR_W-1:0]                 r_rd;
  logic [c_PTR_W:0]                   r_cnt;
  logic                               r_overflow;
  logic [7:0]                         r_drop_cnt;
  logic [15:0]                        r_pkt_cnt;

  logic              w_a_valid;
  logic [ADDR_W-1:0] w_a_addr;
  logic [c_ENT_W-1:0] w_beat;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  // Address/valid delayed to line up with the ROM data of the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_v <= '0;
      r_pipe_a <= '0;
    end else begin
      r_pipe_v[0] <= in_valid;
      r_pipe_a[0] <= in_addr;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        r_pipe_v[i] <= r_pipe_v[i-1];
        r_pipe_a[i] <= r_pipe_a[i-1];
      end
    end
  end

  assign w_a_valid = r_pipe_v[ROM_LATENCY-1];
  assign w_a_addr  = r_pipe_a[ROM_LATENCY-1];
  assign w_beat    = {in_data,
                      (w_a_addr == ADDR_W'(LAST_ADDR)),
                      (w_a_addr == ADDR_W'(FIRST_ADDR)),
                      w_a_addr};

  assign m_tvalid = (r_cnt != '0);
  assign w_full   = (r_cnt == c_DEPTH);
  assign w_pop    = m_tvalid && m_tready;
  assign w_push   = w_a_valid && (!w_full || w_pop);
  assign w_drop   = w_a_valid && w_full && !w_pop;

  assign {m_tdata, m_tlast, m_tuser} = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_beat;
        r_wr        <= r_wr + c_PTR_W'(1);
      end
      if (w_pop) r_rd <= r_rd + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (c_PTR_W + 1)'(1);
        2'b01:   r_cnt <= r_cnt - (c_PTR_W + 1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
      r_pkt_cnt  <= 16'd0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      if (w_pop && m_tlast) r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;
  assign pkt_cnt  = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_flt_stream_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_flt_stream_source
// Description : Scoreboard bench for flt_stream_source (ROM latency 1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flt_stream_source;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [4:0]  u;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_valid3 = 1'b0;
  logic [3:0]  in_addr = 4'd0, in_addr3 = 4'd0;
  logic [31:0] rom1 = '0, rom3_a = '0, rom3_b = '0, rom3 = '0;
  logic        m_tready = 1'b1, m_tready3 = 1'b1;
  logic        m_tvalid, m_tlast, overflow, m_tvalid3, m_tlast3, overflow3;
  logic [31:0] m_tdata, m_tdata3;
  logic [4:0]  m_tuser, m_tuser3;
  logic [7:0]  drop_cnt, drop_cnt3;
  logic [15:0] pkt_cnt, pkt_cnt3;

  int total = 0, bad = 0, cyc = 0;
  int deliv = 0, deliv3 = 0;
  int c1 = 0, c3 = 0, lat1 = -1, lat3 = -1;
  bit arm1 = 0, arm3 = 0, started = 0;
  beat_t exp_q[$];
  beat_t q3[$];
  logic [7:0]  m_drops = 0;
  logic [15:0] m_pkts = 0;

  always #5 clk = ~clk;

  // ROM models: data = 0x3F800000 + address, one and three cycles late
  always @(posedge clk) begin
    rom1   <= 32'h3F800000 + {28'd0, in_addr};
    rom3_a <= 32'h3F800000 + {28'd0, in_addr3};
    rom3_b <= rom3_a;
    rom3   <= rom3_b;
  end

  flt_stream_source dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_data(rom1),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .overflow(overflow), .drop_cnt(drop_cnt), .pkt_cnt(pkt_cnt)
  );

  flt_stream_source #(.ROM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_addr(in_addr3), .in_data(rom3),
    .m_tvalid(m_tvalid3), .m_tready(m_tready3), .m_tdata(m_tdata3), .m_tlast(m_tlast3),
    .m_tuser(m_tuser3), .overflow(overflow3), .drop_cnt(drop_cnt3), .pkt_cnt(pkt_cnt3)
  );

  function automatic beat_t mk(input logic [3:0] a);
    beat_t b;
    b.d = 32'h3F800000 + {28'd0, a};
    b.l = (a == 4'd10);
    b.u = {(a == 4'd1), a};
    return b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int first, input int last_a, input bit rnd);
    for (int a = first; a <= last_a; a++) begin
      in_valid = 1'b1;
      in_addr  = 4'(a);
      if (rnd) m_tready = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Expected-FIFO model for the latency-1 instance: pushes accepted beats, pops on handshake
  initial begin
    logic  pv, pop, full;
    logic [3:0] pa;
    beat_t b;
    pv = 0; pa = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete(); q3.delete();
        pv = 0; m_drops = 0; m_pkts = 0; deliv = 0; deliv3 = 0; started = 1;
      end else begin
        full = (exp_q.size() == 4);
        pop  = (exp_q.size() != 0) && m_tready;
        if (pop) begin
          b = exp_q.pop_front();
          if (b.l) m_pkts++;
        end
        if (pv) begin
          if (!full || pop) exp_q.push_back(mk(pa));
          else if (m_drops != 8'hFF) m_drops++;
        end
        pv = in_valid;
        pa = in_addr;
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard away from the clock edge
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("tvalid", m_tvalid, exp_q.size() != 0);
        if (m_tvalid && exp_q.size() != 0) begin
          chk("tdata", m_tdata, exp_q[0].d);
          chk("tlast", m_tlast, exp_q[0].l);
          chk("tuser", m_tuser, exp_q[0].u);
          if (m_tready) deliv++;
        end
        chk("overflow", overflow, m_drops != 0);
        chk("drop_cnt", drop_cnt, m_drops);
        chk("pkt_cnt", pkt_cnt, m_pkts);
        if (arm1 && m_tvalid) begin lat1 = cyc - c1; arm1 = 0; end
        if (arm3 && m_tvalid3) begin lat3 = cyc - c3; arm3 = 0; end
        if (q3.size() == 0) chk("tvalid3_idle", m_tvalid3, 1'b0);
        else if (m_tvalid3) begin
          chk("tdata3", m_tdata3, q3[0].d);
          chk("tlast3", m_tlast3, q3[0].l);
          chk("tuser3", m_tuser3, q3[0].u);
          b = q3.pop_front();
          deliv3++;
        end
      end
    end
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_tvalid", m_tvalid, 1'b0);
    chk("reset_tdata", m_tdata, 32'd0);
    chk("reset_tuser", m_tuser, 5'd0);

    // Full packet, ready held high
    m_tready = 1'b1;
    c1 = cyc; arm1 = 1;
    send(1, 10, 0);
    repeat (5) tick();
    chk("latency_l1", lat1, 2);
    chk("pkt1_deliv", deliv, 10);
    chk("pkt1_pkt_cnt", pkt_cnt, 16'd1);
    chk("pkt1_overflow", overflow, 1'b0);

    // Stalled from the start: 1..4 stored, 5..10 dropped
    do_reset();
    m_tready = 1'b0;
    send(1, 10, 0);
    repeat (3) tick();
    chk("stall_overflow", overflow, 1'b1);
    chk("stall_drop_cnt", drop_cnt, 8'd6);
    m_tready = 1'b1;
    repeat (8) tick();
    chk("stall_deliv", deliv, 4);
    chk("stall_pkt_cnt", pkt_cnt, 16'd0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    m_tready = 1'b0;
    send(1, 5, 0);
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    repeat (2) tick();
    chk("fullpp_deliv", deliv, 1);
    chk("fullpp_tvalid", m_tvalid, 1'b1);
    chk("fullpp_drop_cnt", drop_cnt, 8'd0);
    m_tready = 1'b1;
    repeat (6) tick();
    chk("fullpp_drain", deliv, 5);

    // Reset with three beats queued mid-packet
    do_reset();
    m_tready = 1'b0;
    send(1, 3, 0);
    repeat (2) tick();
    chk("mid_queued", m_tvalid, 1'b1);
    do_reset();
    chk("mid_rst_tvalid", m_tvalid, 1'b0);
    chk("mid_rst_drop", drop_cnt, 8'd0);
    chk("mid_rst_pkt", pkt_cnt, 16'd0);
    chk("mid_rst_overflow", overflow, 1'b0);
    m_tready = 1'b1;
    send(1, 10, 0);
    repeat (5) tick();
    chk("mid_next_pkt", pkt_cnt, 16'd1);
    chk("mid_next_deliv", deliv, 10);

    // Random back-pressure over four packets
    do_reset();
    for (int p = 0; p < 4; p++) send(1, 10, 1);
    m_tready = 1'b1;
    repeat (10) tick();
    chk("rand_conservation", deliv + int'(drop_cnt), 40);

    // ROM latency 3 instance
    c3 = cyc; arm3 = 1;
    for (int a = 1; a <= 10; a++) begin
      in_valid3 = 1'b1;
      in_addr3  = 4'(a);
      q3.push_back(mk(4'(a)));
      tick();
    end
    in_valid3 = 1'b0;
    repeat (8) tick();
    chk("latency_l3", lat3, 4);
    chk("l3_deliv", deliv3, 10);
    chk("l3_pkt_cnt", pkt_cnt3, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flt_stream_source.md
# flt_stream_source

AXI4-Stream source stage for the on-board floating-point reciprocal test. Sits between the ROM address counter / operand ROM pair and the floating-point core's `s_axis_a` input. It aligns the counter's valid/address with the synchronous ROM's data and generates `tlast` and `tuser` framing. It buffers beats in a small FIFO, because the counter cannot be back-pressured, and reports dropped beats when the core stalls.

## Interface

Parameters:
- `DATA_W`, 32, operand width (single-precision float).
- `ADDR_W`, 4, ROM address width.
- `ROM_LATENCY`, 1, cycles from address to ROM data (1..3).
- `FIRST_ADDR`, 1, address of the first beat of a packet.
- `LAST_ADDR`, 10, address of the last beat of a packet.
- `DEPTH`, 4, FIFO entries (power of two, 2..16).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  counter valid, aligned with `in_addr`.
- `in_addr`  in  ADDR_W  counter address, also driven to ROM.
- `in_data`  in  DATA_W  ROM output, ROM_LATENCY cycles after `in_addr`.
- `m_tvalid`  out  1  stream valid.
- `m_tready`  in  1  stream ready from FP core.
- `m_tdata`  out  DATA_W  operand.
- `m_tlast`  out  1  high on beat whose address == LAST_ADDR.
- `m_tuser`  out  ADDR_W+1  {first flag, address}; bit ADDR_W high when address == FIRST_ADDR.
- `overflow`  out  1  sticky: a beat was dropped since reset.
- `drop_cnt`  out  8  dropped beats, saturates at 255.
- `pkt_cnt`  out  16  packets delivered (handshakes with `m_tlast`), wraps.

## Operation

- Alignment: `in_valid`/`in_addr` pass through a ROM_LATENCY-deep register pipe. Stage output `a_valid`/`a_addr` is paired with `in_data` of the same cycle.
- Beat formed when `a_valid`=1:
  - data = `in_data`
  - last = (`a_addr`==LAST_ADDR)
  - user = {(`a_addr`==FIRST_ADDR), `a_addr`}
- FIFO holds {data, last, user}; `m_*` are driven from the head entry.
- `m_tvalid` = FIFO not empty.
- Pop on `m_tvalid && m_tready`.
- Push accepted when `a_valid` && (count < DEPTH || pop this cycle).
- Full with no pop and `a_valid`=1: the beat is dropped. `overflow` is set to 1 and stays set until reset. `drop_cnt` increments, holding at 255.
- `pkt_cnt` increments on every handshake with `m_tlast`=1, and wraps from 0xFFFF to 0.
- Address 0, or any address outside FIRST_ADDR..LAST_ADDR, is forwarded unchanged if `in_valid`=1; flags are computed only by compare.
- Reset (any cycle, including mid-packet):
  - alignment pipe and FIFO cleared; count=0
  - storage entries zeroed
  - `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `m_tuser`=0
  - `overflow`=0, `drop_cnt`=0, `pkt_cnt`=0
  - In-flight beats are discarded, with no partial packet flagging.
- Head entry is stable while `m_tvalid`=1 and `m_tready`=0 (AXI-Stream rule).

## Timing

- `in_addr` sampled in cycle t: ROM data arrives in cycle t+ROM_LATENCY. The beat is written at the end of that cycle. With an empty FIFO, `m_tvalid`=1 in cycle t+ROM_LATENCY+1.
- Address-to-output latency is therefore ROM_LATENCY+1 cycles (2 by default).
- With `m_tready` held at 1, throughput equals input rate: one beat per cycle. FIFO occupancy stays ≤1.
- Simultaneous push and pop:
  - Count is unchanged.
  - Allowed at full, so no drop occurs.
  - At empty, the new beat appears the next cycle (no combinational bypass).
- `overflow`/`drop_cnt` update in the cycle after the drop. `pkt_cnt` updates in the cycle after the last-beat handshake.
- First cycle after `rst` deasserts: all outputs still at reset values. The alignment pipe emits nothing valid until ROM_LATENCY cycles after `in_valid` goes high.

## Test plan

- Reset, then the counter pattern with bench ROM data = 0x3F800000+addr, `m_tready`=1:
  - 10 beats, addresses 1..10, first `m_tvalid` 2 cycles after `in_addr`=1.
  - `m_tuser`=0x11 on addr 1; `m_tlast`=1 only on addr 10.
  - `pkt_cnt`=1 after the first packet; `overflow`=0.
- `m_tready`=0 from the start, DEPTH=4:
  - Addresses 1..4 stored and addresses 5..10 dropped.
  - `overflow`=1, `drop_cnt`=6.
  - After ready=1, exactly beats 1..4 emerge, in order with correct data.
- Random `m_tready` with 50% duty:
  - Every accepted beat is delivered once, in order.
  - `m_tdata`/`m_tlast`/`m_tuser` stable while stalled.
  - Delivered beats + `drop_cnt` equals input beats.
- Full FIFO with push and pop in the same cycle: beat accepted, count stays 4, `drop_cnt` unchanged.
- Assert `rst` while 3 beats are queued mid-packet: next cycle `m_tvalid`=0 and all counters 0. The following packet starts cleanly at addr 1 with `m_tuser`=0x11.
- ROM_LATENCY=3: addr-to-`m_tvalid` latency is 4 cycles, and data/addr pairing is correct for all 10 beats.
